// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over 32 cycles,
// with single-cycle handling of divide-by-zero and signed-overflow cases.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd,
  output logic        rdWriteEnable
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? neg32(x) : x;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic        div_take;
  logic [63:0] acc_step;
  logic [31:0] rem_step;
  logic [63:0] mres;
  logic [31:0] qres;
  logic [31:0] rres;
  logic [31:0] fin_rd;
  logic        sgn1, sgn2;
  logic        fast_div0, fast_ovf;
  logic [31:0] fast_rd;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Multiply: low half of acc is the shifting multiplier, high half the
    // running sum. Divide: low half is dividend shifting out / quotient in.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_shift = {rem_q, acc_q[31]};
    div_trial = div_shift - {1'b0, b_q};
    div_take  = ~div_trial[32];

    if (op_q[2]) begin
      acc_step = {acc_q[63:32], acc_q[30:0], div_take};
      rem_step = div_take ? div_trial[31:0] : div_shift[31:0];
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
      rem_step = rem_q;
    end

    mres = neg_q ? (~acc_step + 64'd1) : acc_step;
    qres = neg_q ? neg32(acc_step[31:0]) : acc_step[31:0];
    rres = neg_q ? neg32(rem_step) : rem_step;

    case (op_q)
      F_MUL:                     fin_rd = mres[31:0];
      F_MULH, F_MULHSU, F_MULHU: fin_rd = mres[63:32];
      F_DIV, F_DIVU:             fin_rd = qres;
      default:                   fin_rd = rres;
    endcase

    sgn1 = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
           (funct3 == F_DIV)  || (funct3 == F_REM);
    sgn2 = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);

    fast_div0 = funct3[2] && (rs2 == 32'd0);
    fast_ovf  = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (fast_div0) fast_rd = funct3[1] ? rs1 : 32'hFFFF_FFFF;
    else           fast_rd = funct3[1] ? 32'd0 : 32'h8000_0000;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = funct3;
          b_d   = mag32(rs2, sgn2);
          acc_d = {32'd0, mag32(rs1, sgn1)};
          rem_d = 32'd0;
          cnt_d = 5'd0;
          case (funct3)
            F_MULH, F_DIV:   neg_d = rs1[31] ^ rs2[31];
            F_MULHSU, F_REM: neg_d = rs1[31];
            default:         neg_d = 1'b0;
          endcase
          busy_d = 1'b1;
          if (fast_div0 || fast_ovf) begin
            state_d = DONE;
            rd_d    = fast_rd;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          rd_d    = fin_rd;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      neg_q   <= 1'b0;
      cnt_q   <= 5'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      acc_q   <= 64'd0;
      rd_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdWriteEnable = done_q;
  assign rd            = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit: a cycle-level expectation model built from
// RISC-V M arithmetic is compared against the DUT outputs on every falling edge.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, rdWriteEnable;
  logic [31:0] rd;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .rd(rd),
    .rdWriteEnable(rdWriteEnable)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference RV32M arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [63:0]     bits;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      MUL:    begin pu = ua * ub; bits = pu; return bits[31:0]; end
      MULH:   begin p = sa * sb; bits = p; return bits[63:32]; end
      MULHSU: begin p = sa * longint'(ub); bits = p; return bits[63:32]; end
      MULHU:  begin pu = ua * ub; bits = pu; return bits[63:32]; end
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f[2] && b == 32'd0) ||
           ((f == DIV || f == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Expectation model: an accepted op finishes 32 edges later (0 for the
  // fast path), is busy through the DONE cycle, and updates rd on entry.
  int          cyc       = 0;
  bit          m_active  = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_pend    = 32'd0;
  logic [31:0] m_rd      = 32'd0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_active = 1'b0;
        m_rd     = 32'd0;
      end else begin
        bit idle_before;
        idle_before = !m_active;
        cyc++;
        if (m_active && cyc == m_done_at + 1) m_active = 1'b0;
        if (idle_before && start) begin
          m_active  = 1'b1;
          m_done_at = cyc + (is_fast(funct3, rs1, rs2) ? 0 : 32);
          m_pend    = ref_op(funct3, rs1, rs2);
        end
        if (m_active && cyc == m_done_at) m_rd = m_pend;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      begin
        logic ed;
        ed = m_active && (cyc == m_done_at);
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(ed));
        chk("rdWriteEnable", 32'(rdWriteEnable), 32'(ed));
        chk("rd", rd, m_rd);
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit pin, input logic [31:0] lit, input int poke);
    logic [31:0] want;
    int          lat_want;
    int          n;
    want = ref_op(f, a, b);
    if (pin) chk("model_pin", want, lit);
    lat_want = is_fast(f, a, b) ? 0 : 32;
    @(negedge clock);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
      start = (poke > 0 && n == poke);
      if (start) begin funct3 = MULHU; rs1 = rnd_val(); rs2 = rnd_val(); end
    end
    start = 1'b0;
    chk("latency", n, lat_want);
    chk("result", rd, want);
  endtask

  task automatic abort_test();
    @(negedge clock);
    funct3 = MUL; rs1 = 32'd9; rs2 = 32'd11; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_we", 32'(rdWriteEnable), 32'd0);
    chk("abort_rd", rd, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    #1 reset = 1'b1;
    @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rd", rd, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op(MUL,    32'd7,          32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 0);
    run_op(MULH,   32'h8000_0000,  32'h8000_0000, 1, 32'h4000_0000, 0);
    run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0);
    run_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0);
    run_op(DIVU,   32'd100,        32'd7,         1, 32'd14,        0);
    run_op(REMU,   32'd100,        32'd7,         1, 32'd2,         0);
    run_op(DIV,    32'hFFFF_FF9C,  32'd7,         1, 32'hFFFF_FFF2, 0);
    run_op(REM,    32'hFFFF_FF9C,  32'd7,         1, 32'hFFFF_FFFE, 0);
    run_op(DIV,    32'd5,          32'd0,         1, 32'hFFFF_FFFF, 0);
    run_op(REMU,   32'd5,          32'd0,         1, 32'd5,         0);
    run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
    run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 1, 32'd0,         0);

    run_op(MUL, 32'd123, 32'd456, 1, 32'd56088, 5);

    abort_test();
    run_op(MUL, 32'd3, 32'd4, 1, 32'd12, 0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = rnd_val();
      b = rnd_val();
      run_op(f, a, b, 0, 32'd0, 0);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
